alu_seq: RTL
============

# alu_seq

Parametrised, multi-cycle successor to the Phase 1 single-cycle ALU. It accepts one operation at a time over a valid/ready handshake and executes single-cycle ops in one cycle. Shifts/rotates iterate one bit per cycle, and multiply is shift-add over WIDTH cycles. It holds the result until the consumer takes it and keeps a V/N/Z flag register with per-opcode write enables. It sits in the execute stage between operand fetch and writeback.

## Interface
- WIDTH, 16, datapath width; power of 2, ≥8
- LANE, 4, PADDSB/RED lane width; WIDTH % LANE == 0
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation
- opcode  in  4  operation select
- operand1  in  WIDTH  first operand
- operand2  in  WIDTH  second operand; shift amount is operand2[$clog2(WIDTH)-1:0]
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- err  out  1  result came from a reserved opcode; valid with out_valid
- flags  out  3  registered {V,N,Z}

## Operation
- Opcodes:
  - 0 ADD: signed saturating add.
  - 1 SUB: signed saturating operand1−operand2.
  - 2 XOR.
  - 3 RED: sign-extended sum of all signed LANE-bit lanes of both operands.
  - 4 SLL, 5 SRA, 6 ROR: iterative, by shift amount.
  - 7 PADDSB: lanewise signed saturating add, lanes independent.
  - 8 MUL: unsigned shift-add, low WIDTH bits of the product.
  - 9–15: reserved. result=0, err=1.
- FSM states IDLE, EXEC, DONE:
  - in_ready=1 only in IDLE. Accept = in_valid & in_ready.
  - IDLE→DONE on accept of a single-cycle op, or a shift/rotate with amount 0. Result is registered at the accept edge.
  - IDLE→EXEC on accept of a shift/rotate with amount n>0, or MUL. Operands and opcode are latched.
  - EXEC: a shift/rotate moves one bit per cycle with a down-counter. MUL handles one multiplier bit per cycle, LSB first, with an accumulator. EXEC→DONE when the counter reaches 0.
  - DONE: out_valid=1. result/err/flags stay stable until out_ready. DONE→IDLE on out_ready.
- No new operation is accepted in the DONE cycle, even when out_ready=1. The next accept is in IDLE.
- V/N/Z definitions:
  - V: saturation occurred (ADD/SUB only).
  - N: result[WIDTH-1].
  - Z: result==0.
- Flag write enables, per opcode:
  - ADD, SUB: V, N, Z.
  - XOR, SLL, SRA, ROR: Z.
  - MUL: N, Z.
  - RED, PADDSB, reserved: none.
- Flags update at the edge where the state enters DONE. Disabled bits hold their previous value.
- SRA fills with the sign bit. ROR wraps the LSB into the MSB. A shift amount ≥WIDTH cannot occur, because operand2 is truncated to the shift-amount field.
- PADDSB: each lane clamps to [−2^(LANE−1), 2^(LANE−1)−1]. No carry crosses lanes.

## Timing
- Reset (rst=0, async):
  - state=IDLE.
  - in_ready=1 once reset is released.
  - out_valid=0, result=0, err=0, flags=3'b000.
  - Any in-flight EXEC or DONE operation is discarded, with no output pulse.
- Latency is measured from the accept edge to out_valid high:
  - 1 cycle for single-cycle ops and amount-0 shifts.
  - n+1 cycles for a shift/rotate by n.
  - WIDTH+1 cycles for MUL.
- Throughput: at most one op every latency+1 cycles, plus any out_ready stall.
- Operands and opcode are sampled only at accept. Changes afterwards have no effect.
- out_valid and result are glitch-free register outputs. Nothing has a combinational path from the inputs to the outputs, except none needed for in_ready (state-decoded only).

## Test plan
- **ADD saturation.** Reset, then ADD 0x7FFF+0x0001. Required: out_valid one cycle after accept, result=0x7FFF, flags=3'b100.
- **SRA timing and flag hold.** After the ADD, SRA 0x8000 by 4. Required:
  - in_ready low for 5 cycles, out_valid at accept+5.
  - result=0xF800.
  - flags=3'b100: Z written 0, V and N held.
- **Amount-0 rotate and PADDSB.** ROR 0x1234 by 0 gives 0x1234 at accept+1. PADDSB 0x7878+0x1188 (LANE=4) gives 0x79F8, flags unchanged.
- **MUL.** MUL 0x0003×0xFFFF. Required: result=0xFFFD at accept+17, N=1, Z=0, V held.
- **Backpressure and reserved opcode.** Hold out_ready low 3 cycles on a completed XOR 0xAAAA^0xAAAA. Required:
  - result=0 and flags Z=1 stay stable; in_ready stays 0.
  - After out_ready, the next accept is possible one cycle later.
  - Opcode 9 gives result=0, err=1, flags unchanged.
- **Reset mid-operation.** Assert rst low during MUL EXEC. Required: out_valid=0 and flags=000 immediately, no result after release, in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: valid/ready in, held result out, {V,N,Z} flag register.
// Single-cycle ops finish at accept; shifts/rotates step one bit per cycle; MUL is shift-add.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [2:0]       flags
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;
  localparam int unsigned NL = WIDTH / LANE;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_RED    = 4'd3;
  localparam logic [3:0] OP_SLL    = 4'd4;
  localparam logic [3:0] OP_SRA    = 4'd5;
  localparam logic [3:0] OP_ROR    = 4'd6;
  localparam logic [3:0] OP_PADDSB = 4'd7;
  localparam logic [3:0] OP_MUL    = 4'd8;

  localparam logic [WIDTH-1:0] WMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] WMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LMIN = {1'b1, {(LANE-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [2:0]       flags_q, flags_d;

  logic [WIDTH-1:0] sc_res;
  logic             sc_v;
  logic             sc_err;
  logic [WIDTH:0]   addsub;
  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] ex_res;
  logic [SW-1:0]    amt;
  logic             is_shift;

  // Returns {V, saturated result} of a signed add or subtract.
  function automatic logic [WIDTH:0] sat_addsub(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             sub);
    logic [WIDTH:0] s;
    s = sub ? ({x[WIDTH-1], x} - {y[WIDTH-1], y}) : ({x[WIDTH-1], x} + {y[WIDTH-1], y});
    if (s[WIDTH] != s[WIDTH-1]) return {1'b1, (s[WIDTH] ? WMIN : WMAX)};
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH-1:0] red_sum(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < int'(NL); i++) begin
      s = s + {{(WIDTH-LANE){x[i*LANE+LANE-1]}}, x[i*LANE +: LANE]}
            + {{(WIDTH-LANE){y[i*LANE+LANE-1]}}, y[i*LANE +: LANE]};
    end
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] paddsb(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    logic [LANE:0]    s;
    r = '0;
    for (int i = 0; i < int'(NL); i++) begin
      s = {x[i*LANE+LANE-1], x[i*LANE +: LANE]} + {y[i*LANE+LANE-1], y[i*LANE +: LANE]};
      r[i*LANE +: LANE] = (s[LANE] != s[LANE-1]) ? (s[LANE] ? LMIN : LMAX) : s[LANE-1:0];
    end
    return r;
  endfunction

  // Applies the per-opcode flag write enables; disabled bits keep their old value.
  function automatic logic [2:0] upd_flags(input logic [3:0]       op,
                                           input logic [WIDTH-1:0] res,
                                           input logic             v,
                                           input logic [2:0]       old);
    logic [2:0] f;
    f = old;
    if (op == OP_ADD || op == OP_SUB) f[2] = v;
    if (op == OP_ADD || op == OP_SUB || op == OP_MUL) f[1] = res[WIDTH-1];
    if (op == OP_ADD || op == OP_SUB || op == OP_XOR || op == OP_SLL ||
        op == OP_SRA || op == OP_ROR || op == OP_MUL) f[0] = (res == '0);
    return f;
  endfunction

  assign amt      = operand2[SW-1:0];
  assign is_shift = (opcode == OP_SLL) || (opcode == OP_SRA) || (opcode == OP_ROR);
  assign addsub   = sat_addsub(operand1, operand2, opcode == OP_SUB);

  // Results of ops that complete in the accept cycle.
  always_comb begin
    sc_res = '0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB:         {sc_v, sc_res} = addsub;
      OP_XOR:                 sc_res = operand1 ^ operand2;
      OP_RED:                 sc_res = red_sum(operand1, operand2);
      OP_SLL, OP_SRA, OP_ROR: sc_res = operand1;
      OP_PADDSB:              sc_res = paddsb(operand1, operand2);
      OP_MUL:                 sc_res = '0;
      default:                sc_err = 1'b1;
    endcase
  end

  // One iteration of the latched multi-cycle op.
  always_comb begin
    a_step = a_q;
    case (op_q)
      OP_SLL, OP_MUL: a_step = {a_q[WIDTH-2:0], 1'b0};
      OP_SRA:         a_step = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      OP_ROR:         a_step = {a_q[0], a_q[WIDTH-1:1]};
      default:        a_step = a_q;
    endcase
    acc_step = acc_q + (b_q[0] ? a_q : '0);
    ex_res   = (op_q == OP_MUL) ? acc_step : a_step;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = opcode;
          if (is_shift && amt != '0) begin
            state_d = S_EXEC;
            a_d     = operand1;
            cnt_d   = CW'(amt);
          end else if (opcode == OP_MUL) begin
            state_d = S_EXEC;
            a_d     = operand1;
            b_d     = operand2;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
          end else begin
            state_d  = S_DONE;
            result_d = sc_res;
            err_d    = sc_err;
            flags_d  = upd_flags(opcode, sc_res, sc_v, flags_q);
          end
        end
      end
      S_EXEC: begin
        a_d   = a_step;
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = ex_res;
          err_d    = 1'b0;
          flags_d  = upd_flags(op_q, ex_res, 1'b0, flags_q);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      flags_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      flags_q  <= flags_d;
    end
  end

  // Handshake signals are pure decodes of the state register.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign err       = err_q;
  assign flags     = flags_q;

endmodule
